clint_timer_initiator: RTL and testbench

//  Bus initiator that drives the CLINT register window over the valid/ready memory bus on behalf of
//  a simple command port. Performs tear-free 64-bit mtime reads (hi-lo-hi with retry), glitch-free

---
 rtl/clint_timer_initiator.sv | 242 ++++++++++++++++++++++++
 tb/tb_clint_timer_initiator.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clint_timer_initiator.sv
// CLINT register-window bus initiator: tear-free mtime reads, glitch-free mtimecmp
// updates, mtimecmp reads and msip writes, driven from a single-command port.
module clint_timer_initiator #(
  parameter logic [31:0] BASE_ADDR      = 32'h1100_0000,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [63:0] cmd_data,
  output logic        rsp_valid,
  output logic [63:0] rsp_data,
  output logic        rsp_err,
  output logic        valid,
  output logic [31:0] addr,
  output logic [3:0]  wmask,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  input  logic        ready
);

  localparam int unsigned   TW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned   RW     = $clog2(MAX_RETRY + 2);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRY);

  localparam logic [31:0] A_MSIP = BASE_ADDR + 32'h0000_0000;
  localparam logic [31:0] A_CMPL = BASE_ADDR + 32'h0000_4000;
  localparam logic [31:0] A_CMPH = BASE_ADDR + 32'h0000_4004;
  localparam logic [31:0] A_MTL  = BASE_ADDR + 32'h0000_BFF8;
  localparam logic [31:0] A_MTH  = BASE_ADDR + 32'h0000_BFFC;

  localparam logic [1:0] OP_RD_MTIME = 2'b00;
  localparam logic [1:0] OP_WR_CMP   = 2'b01;
  localparam logic [1:0] OP_WR_MSIP  = 2'b10;
  localparam logic [1:0] OP_RD_CMP   = 2'b11;

  typedef enum logic [1:0] {IDLE, REQ, GAP, RESP} state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [3:0]  m;
    logic [31:0] w;
  } acc_t;

  // Bus access issued for a given step of each command sequence.
  function automatic acc_t access(input logic [1:0] op, input logic [1:0] step,
                                  input logic [63:0] d);
    acc_t r;
    r = '0;
    case (op)
      OP_RD_MTIME: r.a = (step == 2'd1) ? A_MTL : A_MTH;
      OP_WR_CMP: begin
        r.a = (step == 2'd1) ? A_CMPH : A_CMPL;
        r.m = 4'hF;
        case (step)
          2'd0:    r.w = '1;
          2'd1:    r.w = d[63:32];
          default: r.w = d[31:0];
        endcase
      end
      OP_WR_MSIP: begin
        r.a = A_MSIP;
        r.m = 4'hF;
        r.w = {31'b0, d[0]};
      end
      default: r.a = (step == 2'd0) ? A_CMPL : A_CMPH;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] last_step(input logic [1:0] op);
    case (op)
      OP_WR_MSIP: return 2'd0;
      OP_RD_CMP:  return 2'd1;
      default:    return 2'd2;
    endcase
  endfunction

  state_t        state, state_n;
  logic [1:0]    op_q, op_n;
  logic [63:0]   data_q, data_n;
  logic [1:0]    step_q, step_n;
  logic [RW-1:0] retry_q, retry_n;
  logic [TW-1:0] tcnt_q, tcnt_n;
  logic          abort_q, abort_n;
  logic [31:0]   hi1_q, hi1_n, lo_q, lo_n, hi2_q, hi2_n;
  logic          cmd_ready_n, valid_n, rsp_valid_n, rsp_err_n;
  logic [31:0]   addr_n, wdata_n;
  logic [3:0]    wmask_n;
  logic [63:0]   rsp_data_n;
  logic          launch;
  acc_t          nxt;

  always_comb begin
    state_n     = state;
    op_n        = op_q;
    data_n      = data_q;
    step_n      = step_q;
    retry_n     = retry_q;
    tcnt_n      = tcnt_q;
    abort_n     = abort_q;
    hi1_n       = hi1_q;
    lo_n        = lo_q;
    hi2_n       = hi2_q;
    cmd_ready_n = cmd_ready;
    valid_n     = valid;
    addr_n      = addr;
    wmask_n     = wmask;
    wdata_n     = wdata;
    rsp_valid_n = 1'b0;
    rsp_data_n  = rsp_data;
    rsp_err_n   = rsp_err;
    launch      = 1'b0;
    nxt         = '0;

    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_n        = cmd_op;
          data_n      = cmd_data;
          step_n      = '0;
          retry_n     = '0;
          abort_n     = 1'b0;
          cmd_ready_n = 1'b0;
          launch      = 1'b1;
        end
      end
      REQ: begin
        if (ready) begin
          if (op_q == OP_RD_MTIME) begin
            case (step_q)
              2'd0:    hi1_n = rdata;
              2'd1:    lo_n  = rdata;
              default: hi2_n = rdata;
            endcase
          end else if (op_q == OP_RD_CMP) begin
            if (step_q == 2'd0) lo_n  = rdata;
            else                hi2_n = rdata;
          end
          valid_n = 1'b0;
          state_n = GAP;
        end else if (tcnt_q == T_LAST) begin
          valid_n = 1'b0;
          abort_n = 1'b1;
          state_n = GAP;
        end else begin
          tcnt_n = tcnt_q + TW'(1);
        end
      end
      GAP: begin
        if (abort_q) begin
          state_n     = RESP;
          rsp_valid_n = 1'b1;
          rsp_data_n  = '0;
          rsp_err_n   = 1'b1;
        end else if (step_q != last_step(op_q)) begin
          step_n = step_q + 2'd1;
          launch = 1'b1;
        end else if (op_q == OP_RD_MTIME && hi1_q != hi2_q && retry_q < R_MAX) begin
          retry_n = retry_q + RW'(1);
          step_n  = '0;
          launch  = 1'b1;
        end else begin
          state_n     = RESP;
          rsp_valid_n = 1'b1;
          rsp_err_n   = 1'b0;
          case (op_q)
            // On a clean pass hi1 == hi2, so {hi2, lo} is the result either way.
            OP_RD_MTIME: begin
              rsp_data_n = {hi2_q, lo_q};
              rsp_err_n  = (hi1_q != hi2_q);
            end
            OP_RD_CMP: rsp_data_n = {hi2_q, lo_q};
            default:   rsp_data_n = '0;
          endcase
        end
      end
      RESP: begin
        state_n     = IDLE;
        cmd_ready_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase

    if (launch) begin
      nxt     = access(op_n, step_n, data_n);
      state_n = REQ;
      valid_n = 1'b1;
      addr_n  = nxt.a;
      wmask_n = nxt.m;
      wdata_n = nxt.w;
      tcnt_n  = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      op_q      <= '0;
      data_q    <= '0;
      step_q    <= '0;
      retry_q   <= '0;
      tcnt_q    <= '0;
      abort_q   <= 1'b0;
      hi1_q     <= '0;
      lo_q      <= '0;
      hi2_q     <= '0;
      cmd_ready <= 1'b1;
      valid     <= 1'b0;
      addr      <= '0;
      wmask     <= '0;
      wdata     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_n;
      op_q      <= op_n;
      data_q    <= data_n;
      step_q    <= step_n;
      retry_q   <= retry_n;
      tcnt_q    <= tcnt_n;
      abort_q   <= abort_n;
      hi1_q     <= hi1_n;
      lo_q      <= lo_n;
      hi2_q     <= hi2_n;
      cmd_ready <= cmd_ready_n;
      valid     <= valid_n;
      addr      <= addr_n;
      wmask     <= wmask_n;
      wdata     <= wdata_n;
      rsp_valid <= rsp_valid_n;
      rsp_data  <= rsp_data_n;
      rsp_err   <= rsp_err_n;
    end
  end

endmodule

// File: tb/tb_clint_timer_initiator.sv
// Bench for clint_timer_initiator: CLINT responder with programmable mtime drift,
// plus a command-level reference model of the expected bus traffic and responses.
module tb_clint_timer_initiator;

  localparam logic [31:0] BASE   = 32'h1100_0000;
  localparam logic [31:0] A_MSIP = BASE + 32'h0000_0000;
  localparam logic [31:0] A_CMPL = BASE + 32'h0000_4000;
  localparam logic [31:0] A_CMPH = BASE + 32'h0000_4004;
  localparam logic [31:0] A_MTL  = BASE + 32'h0000_BFF8;
  localparam logic [31:0] A_MTH  = BASE + 32'h0000_BFFC;
  localparam int          TMO    = 64;
  localparam int          MAXR   = 3;

  typedef struct packed {
    logic [31:0] a;
    logic [3:0]  m;
    logic [31:0] w;
  } acc_t;

  logic        clk = 1'b0;
  logic        resetn, cmd_valid, cmd_ready, rsp_valid, rsp_err, valid, ready;
  logic [1:0]  cmd_op;
  logic [63:0] cmd_data, rsp_data;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  wmask;

  always #5 clk = ~clk;

  clint_timer_initiator #(
    .BASE_ADDR      (BASE),
    .TIMEOUT_CYCLES (TMO),
    .MAX_RETRY      (MAXR)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .valid     (valid),
    .addr      (addr),
    .wmask     (wmask),
    .wdata     (wdata),
    .rdata     (rdata),
    .ready     (ready)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Responder configuration and register state.
  logic [63:0] r_mtime = '0, r_cmp = '0, tick = '0;
  logic        r_msip = 1'b0;
  bit          no_ready = 0, linger = 0;
  int          max_lat = 0, lat = 0;
  int          vhigh = 0, gap_err = 0, stab_err = 0;
  int          busy_rdy_total = 0, rdy_rsp_total = 0;
  acc_t        log_q[$];

  // Reference model state.
  logic [63:0] m_mtime = '0, m_cmp = '0;
  acc_t        exp_q[$];

  function automatic acc_t mk(input logic [31:0] a, input logic [3:0] m, input logic [31:0] w);
    acc_t r;
    r.a = a; r.m = m; r.w = w;
    return r;
  endfunction

  // Responder: ready rises no sooner than the second valid cycle, stays one cycle
  // (optionally lingering into the gap), rdata is garbage outside ready cycles.
  initial begin
    int   vcnt;
    int   phase;
    acc_t snap;
    acc_t cur;
    vcnt = 0; phase = 0; snap = '0;
    ready = 1'b0; rdata = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        ready = 1'b0; phase = 0; vcnt = 0;
      end else begin
        if (valid) vhigh++;
        if (phase == 1) begin
          if (valid) gap_err++;
          rdata = $urandom;
          if (linger) phase = 2;
          else begin ready = 1'b0; phase = 0; end
        end else if (phase == 2) begin
          ready = 1'b0; phase = 0;
        end
        if (phase == 0) begin
          if (valid) begin
            vcnt++;
            cur = mk(addr, wmask, wdata);
            if (vcnt == 1) snap = cur;
            else if (cur !== snap) stab_err++;
            if (!no_ready && vcnt >= 2 + lat) begin
              log_q.push_back(cur);
              rdata = $urandom;
              case (addr)
                A_MTH: rdata = r_mtime[63:32];
                A_MTL: begin rdata = r_mtime[31:0]; r_mtime = r_mtime + tick; end
                A_CMPL: if (wmask == 4'hF) r_cmp[31:0] = wdata; else rdata = r_cmp[31:0];
                A_CMPH: if (wmask == 4'hF) r_cmp[63:32] = wdata; else rdata = r_cmp[63:32];
                A_MSIP: if (wmask == 4'hF) r_msip = wdata[0]; else rdata = {31'b0, r_msip};
                default: ;
              endcase
              ready = 1'b1; phase = 1; vcnt = 0;
              lat = $urandom_range(0, max_lat);
            end
          end else begin
            vcnt = 0;
          end
        end
      end
    end
  end

  // Command-level model: expected bus sequence and response from the op's rules.
  function automatic void model(input logic [1:0] op, input logic [63:0] d,
                                output logic [63:0] rd, output logic re);
    logic [31:0] h1, l, h2;
    bit done;
    exp_q.delete();
    rd = '0; re = 1'b0; done = 0;
    case (op)
      2'b00: begin
        re = 1'b1;
        for (int p = 0; p <= MAXR && !done; p++) begin
          exp_q.push_back(mk(A_MTH, 4'h0, 32'h0));
          exp_q.push_back(mk(A_MTL, 4'h0, 32'h0));
          exp_q.push_back(mk(A_MTH, 4'h0, 32'h0));
          h1 = m_mtime[63:32];
          l  = m_mtime[31:0];
          m_mtime = m_mtime + tick;
          h2 = m_mtime[63:32];
          rd = {h2, l};
          if (h1 == h2) begin re = 1'b0; done = 1; end
        end
      end
      2'b01: begin
        exp_q.push_back(mk(A_CMPL, 4'hF, 32'hFFFF_FFFF));
        exp_q.push_back(mk(A_CMPH, 4'hF, d[63:32]));
        exp_q.push_back(mk(A_CMPL, 4'hF, d[31:0]));
        m_cmp = d;
      end
      2'b10: exp_q.push_back(mk(A_MSIP, 4'hF, {31'b0, d[0]}));
      default: begin
        exp_q.push_back(mk(A_CMPL, 4'h0, 32'h0));
        exp_q.push_back(mk(A_CMPH, 4'h0, 32'h0));
        rd = m_cmp;
      end
    endcase
  endfunction

  task automatic run_cmd(input logic [1:0] op, input logic [63:0] d, input bit hold,
                         output logic [63:0] rd, output logic re, output bit to,
                         output int pulses);
    int n;
    to = 1; pulses = 0; rd = '0; re = 1'b0;
    n = 0;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    log_q.delete();
    vhigh = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    @(negedge clk);
    if (hold) begin
      cmd_op = op ^ 2'b01; cmd_data = ~d;
    end else begin
      cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_data = {$urandom, $urandom};
    end
    for (n = 0; n < 2000 && to; n++) begin
      if (rsp_valid) begin
        rd = rsp_data; re = rsp_err; to = 0; pulses = 1;
        if (cmd_ready) rdy_rsp_total++;
        cmd_valid = 1'b0;
      end else if (cmd_ready) begin
        busy_rdy_total++;
      end
      @(negedge clk);
    end
    if (rsp_valid) pulses++;
    cmd_valid = 1'b0;
  endtask

  task automatic exec(input logic [1:0] op, input logic [63:0] d, input bit hold,
                      output logic [63:0] rd, output logic [63:0] erd,
                      output logic re, output logic ere, output bit to,
                      output int pulses, output bit log_ok, output int nlog);
    model(op, d, erd, ere);
    run_cmd(op, d, hold, rd, re, to, pulses);
    nlog = log_q.size();
    log_ok = (log_q.size() == exp_q.size());
    for (int i = 0; i < log_q.size() && log_ok; i++)
      if (log_q[i] !== exp_q[i]) log_ok = 0;
  endtask

  task automatic test_reset;
    resetn = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    n_checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); else n_pass++;
    n_checks++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid); else n_pass++;
    n_checks++; if (addr !== 32'h0) $display("FAIL reset_addr: got %h want 0", addr); else n_pass++;
    n_checks++; if (wmask !== 4'h0) $display("FAIL reset_wmask: got %h want 0", wmask); else n_pass++;
    n_checks++; if (wdata !== 32'h0) $display("FAIL reset_wdata: got %h want 0", wdata); else n_pass++;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
    n_checks++; if (rsp_data !== 64'h0) $display("FAIL reset_rsp_data: got %h want 0", rsp_data); else n_pass++;
    n_checks++; if (rsp_err !== 1'b0) $display("FAIL reset_rsp_err: got %b want 0", rsp_err); else n_pass++;
  endtask

  task automatic test_mtime_stable;
    logic [63:0] rd, erd; logic re, ere; bit to, ok; int p, nl;
    r_mtime = 64'h0000_1234_5678_9ABC; m_mtime = r_mtime; tick = '0;
    linger = 0; max_lat = 0; lat = 0;
    exec(2'b00, 64'h0, 0, rd, erd, re, ere, to, p, ok, nl);
    n_checks++; if (to || p != 1) $display("FAIL stable_rsp: timeout=%0d pulses=%0d want 0/1", to, p); else n_pass++;
    n_checks++; if (rd !== 64'h0000_1234_5678_9ABC) $display("FAIL stable_data: got %h want 0000123456789abc", rd); else n_pass++;
    n_checks++; if (re !== 1'b0) $display("FAIL stable_err: got %b want 0", re); else n_pass++;
    n_checks++; if (!ok || nl != 3) $display("FAIL stable_bus: %0d accesses want 3 (BFFC,BFF8,BFFC)", nl); else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++; if (rsp_data !== 64'h0000_1234_5678_9ABC) $display("FAIL stable_hold: got %h want 0000123456789abc", rsp_data); else n_pass++;
  endtask

  task automatic test_mtime_wrap;
    logic [63:0] rd, erd; logic re, ere; bit to, ok; int p, nl;
    r_mtime = 64'h0000_0001_FFFF_FFFF; m_mtime = r_mtime; tick = 64'd1;
    linger = 1; max_lat = 1;
    exec(2'b00, 64'h0, 0, rd, erd, re, ere, to, p, ok, nl);
    n_checks++; if (to || p != 1) $display("FAIL wrap_rsp: timeout=%0d pulses=%0d want 0/1", to, p); else n_pass++;
    n_checks++; if (rd !== 64'h0000_0002_0000_0000) $display("FAIL wrap_data: got %h want 0000000200000000", rd); else n_pass++;
    n_checks++; if (re !== 1'b0) $display("FAIL wrap_err: got %b want 0", re); else n_pass++;
    n_checks++; if (!ok || nl != 6) $display("FAIL wrap_bus: %0d accesses want 6 in model order", nl); else n_pass++;
  endtask

  task automatic test_cmp_write;
    logic [63:0] rd, erd; logic re, ere; bit to, ok; int p, nl;
    tick = '0; linger = 1; max_lat = 2;
    exec(2'b01, 64'h0000_00AB_0000_1000, 0, rd, erd, re, ere, to, p, ok, nl);
    n_checks++; if (to || p != 1) $display("FAIL cmpw_rsp: timeout=%0d pulses=%0d want 0/1", to, p); else n_pass++;
    n_checks++; if (rd !== 64'h0 || re !== 1'b0) $display("FAIL cmpw_result: data=%h err=%b want 0/0", rd, re); else n_pass++;
    n_checks++; if (!ok || nl != 3) $display("FAIL cmpw_bus: %0d accesses want 3 (4000=FFFFFFFF,4004=AB,4000=1000)", nl); else n_pass++;
    n_checks++; if (r_cmp !== 64'h0000_00AB_0000_1000) $display("FAIL cmpw_value: got %h want 000000ab00001000", r_cmp); else n_pass++;
  endtask

  task automatic test_timeout;
    logic [63:0] rd; logic re; bit to; int p;
    no_ready = 1; linger = 0;
    run_cmd(2'b10, 64'h1, 0, rd, re, to, p);
    no_ready = 0;
    n_checks++; if (to || p != 1) $display("FAIL tmo_rsp: timeout=%0d pulses=%0d want 0/1", to, p); else n_pass++;
    n_checks++; if (re !== 1'b1 || rd !== 64'h0) $display("FAIL tmo_result: data=%h err=%b want 0/1", rd, re); else n_pass++;
    n_checks++; if (vhigh != TMO) $display("FAIL tmo_valid_cycles: got %0d want %0d", vhigh, TMO); else n_pass++;
    n_checks++; if (r_msip !== 1'b0) $display("FAIL tmo_msip: got %b want 0", r_msip); else n_pass++;
  endtask

  task automatic test_retry_exhaust;
    logic [63:0] rd, erd; logic re, ere; bit to, ok; int p, nl;
    r_mtime = {16'h0, 16'($urandom), 32'($urandom)}; m_mtime = r_mtime;
    tick = 64'h1_0000_0000; linger = 1; max_lat = 3;
    exec(2'b00, 64'h0, 0, rd, erd, re, ere, to, p, ok, nl);
    n_checks++; if (to || p != 1) $display("FAIL exhaust_rsp: timeout=%0d pulses=%0d want 0/1", to, p); else n_pass++;
    n_checks++; if (re !== 1'b1) $display("FAIL exhaust_err: got %b want 1", re); else n_pass++;
    n_checks++; if (rd !== erd) $display("FAIL exhaust_data: got %h want %h", rd, erd); else n_pass++;
    n_checks++; if (!ok || nl != 12) $display("FAIL exhaust_bus: %0d accesses want 12", nl); else n_pass++;
    tick = '0;
    exec(2'b11, 64'h0, 0, rd, erd, re, ere, to, p, ok, nl);
    n_checks++; if (to || p != 1) $display("FAIL cmprd_rsp: timeout=%0d pulses=%0d want 0/1", to, p); else n_pass++;
    n_checks++; if (rd !== 64'h0000_00AB_0000_1000 || re !== 1'b0) $display("FAIL cmprd_data: got %h err=%b want 000000ab00001000/0", rd, re); else n_pass++;
    n_checks++; if (!ok) $display("FAIL cmprd_bus: %0d accesses want 2 (4000,4004)", nl); else n_pass++;
  endtask

  task automatic test_random;
    logic [63:0] rd, erd, d; logic re, ere; bit to, ok, hold; int p, nl;
    logic [1:0] op;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      d = {$urandom, $urandom};
      hold = 1'($urandom);
      linger = 1'($urandom);
      max_lat = $urandom_range(0, 3);
      case ($urandom_range(0, 3))
        0: tick = '0;
        1: tick = 64'd1;
        2: tick = 64'h1_0000_0000;
        default: tick = 64'($urandom_range(1, 1000));
      endcase
      r_mtime = {16'h0, 16'($urandom), 32'hFFFF_FFFF - 32'($urandom_range(0, 3))};
      m_mtime = r_mtime;
      exec(op, d, hold, rd, erd, re, ere, to, p, ok, nl);
      n_checks++; if (to || p != 1) $display("FAIL rnd%0d_rsp: op=%0d timeout=%0d pulses=%0d want 0/1", i, op, to, p); else n_pass++;
      n_checks++; if (rd !== erd) $display("FAIL rnd%0d_data: op=%0d got %h want %h", i, op, rd, erd); else n_pass++;
      n_checks++; if (re !== ere) $display("FAIL rnd%0d_err: op=%0d got %b want %b", i, op, re, ere); else n_pass++;
      n_checks++; if (!ok) $display("FAIL rnd%0d_bus: op=%0d %0d accesses want %0d matching", i, op, nl, exp_q.size()); else n_pass++;
    end
  endtask

  task automatic test_reset_mid;
    logic [63:0] rd, erd; logic re, ere; bit to, ok, found; int p, nl, seen;
    linger = 0; max_lat = 0; lat = 0; tick = '0;
    while (!cmd_ready) @(negedge clk);
    log_q.delete();
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = 64'h0000_0055_0000_2222;
    @(negedge clk);
    cmd_valid = 1'b0;
    found = 0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk); #2;
      if (log_q.size() == 1 && valid && !ready) found = 1;
    end
    n_checks++; if (!found) $display("FAIL rstmid_reach_step1: got step1 REQ=0 want 1"); else n_pass++;
    resetn = 1'b0;
    #1;
    n_checks++; if (valid !== 1'b0) $display("FAIL rstmid_valid_drop: got %b want 0", valid); else n_pass++;
    seen = 0;
    repeat (2) begin @(negedge clk); if (rsp_valid) seen++; end
    resetn = 1'b1;
    @(negedge clk);
    n_checks++; if (cmd_ready !== 1'b1) $display("FAIL rstmid_cmd_ready: got %b want 1", cmd_ready); else n_pass++;
    repeat (4) begin @(negedge clk); if (rsp_valid) seen++; end
    n_checks++; if (seen != 0) $display("FAIL rstmid_no_rsp: got %0d pulses want 0", seen); else n_pass++;
    m_cmp[31:0] = 32'hFFFF_FFFF;
    exec(2'b10, 64'h1, 0, rd, erd, re, ere, to, p, ok, nl);
    n_checks++; if (to || re !== 1'b0 || !ok) $display("FAIL rstmid_msip_op: timeout=%0d err=%b bus_ok=%0d want 0/0/1", to, re, ok); else n_pass++;
    n_checks++; if (r_msip !== 1'b1) $display("FAIL rstmid_msip_value: got %b want 1", r_msip); else n_pass++;
    exec(2'b11, 64'h0, 0, rd, erd, re, ere, to, p, ok, nl);
    n_checks++; if (rd !== erd) $display("FAIL rstmid_cmp_partial: got %h want %h", rd, erd); else n_pass++;
  endtask

  task automatic test_back_to_back;
    n_checks++; if (gap_err != 0) $display("FAIL gap_cycle: got %0d accesses without idle gap want 0", gap_err); else n_pass++;
    n_checks++; if (stab_err != 0) $display("FAIL req_stable: got %0d changes while valid want 0", stab_err); else n_pass++;
    n_checks++; if (busy_rdy_total != 0) $display("FAIL busy_cmd_ready: got %0d busy cycles with cmd_ready want 0", busy_rdy_total); else n_pass++;
    n_checks++; if (rdy_rsp_total != 0) $display("FAIL rsp_cmd_ready: got %0d rsp cycles with cmd_ready want 0", rdy_rsp_total); else n_pass++;
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset;
    test_mtime_stable;
    test_mtime_wrap;
    test_cmp_write;
    test_timeout;
    test_retry_exhaust;
    test_random;
    test_reset_mid;
    test_back_to_back;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
